// File: rtl/cruise_regulator.sv
// Cruise regulator: debounces comparator G/Eq/L flags and ramps a registered throttle level.
// Optional CRUISE_FAULT_LATCH_EN latches a fault on invalid flags while cruising.
module cruise_regulator #(
  parameter int W        = 8,
  parameter int DEBOUNCE = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         engage,
  input  logic         cancel,
  input  logic [W-1:0] pedal_level,
  input  logic         G,
  input  logic         Eq,
  input  logic         L,
  output logic [W-1:0] throttle,
  output logic [1:0]   state,
  output logic         active,
  output logic         accel,
  output logic         decel,
  output logic         fault
);

  typedef enum logic [1:0] {
    OFF   = 2'b00,
    HOLD  = 2'b01,
    ACCEL = 2'b10,
    DECEL = 2'b11
  } state_t;

  localparam logic [3:0] DB = 4'(DEBOUNCE);

  state_t         state_q, state_d;
  state_t         prev_q, prev_d;
  state_t         demand;
  logic           prev_vld_q, prev_vld_d;
  logic [W-1:0]   thr_q, thr_d, thr_step;
  logic [3:0]     cnt_q, cnt_d, cnt_sample;
  logic           flags_valid;
  logic           fault_q, fault_d;

  // Flags are one-hot when valid; demand is only meaningful when flags_valid.
  always_comb begin
    flags_valid = 1'b0;
    demand      = HOLD;
    case ({G, Eq, L})
      3'b100:  begin flags_valid = 1'b1; demand = DECEL; end
      3'b010:  begin flags_valid = 1'b1; demand = HOLD;  end
      3'b001:  begin flags_valid = 1'b1; demand = ACCEL; end
      default: begin flags_valid = 1'b0; demand = HOLD;  end
    endcase
  end

  // Throttle motion is driven by the registered state, never the next state.
  always_comb begin
    case (state_q)
      ACCEL:   thr_step = (thr_q == '1) ? thr_q : thr_q + W'(1);
      DECEL:   thr_step = (thr_q == '0) ? thr_q : thr_q - W'(1);
      HOLD:    thr_step = thr_q;
      default: thr_step = '0;
    endcase
  end

  // A demand that differs from last cycle's starts a fresh run at 1.
  assign cnt_sample = (prev_vld_q && (prev_q == demand)) ? cnt_q + 4'd1 : 4'd1;

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_step;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    fault_d    = fault_q;
    if (state_q == OFF) begin
      thr_d      = '0;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
      if (engage && !cancel && !fault_q) begin
        state_d = HOLD;
        thr_d   = pedal_level;
      end
    end else if (cancel) begin
      state_d    = OFF;
      thr_d      = '0;
      cnt_d      = '0;
      prev_vld_d = 1'b0;
    end else if (!flags_valid) begin
      cnt_d      = '0;
      prev_vld_d = 1'b0;
`ifdef CRUISE_FAULT_LATCH_EN
      fault_d    = 1'b1;
      state_d    = OFF;
      thr_d      = '0;
`endif
    end else begin
      prev_d     = demand;
      prev_vld_d = 1'b1;
      if (demand == state_q) begin
        cnt_d = '0;
      end else if (cnt_sample >= DB) begin
        state_d = demand;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= OFF;
      thr_q      <= '0;
      cnt_q      <= '0;
      prev_q     <= HOLD;
      prev_vld_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      fault_q    <= fault_d;
    end
  end

  assign throttle = thr_q;
  assign state    = state_q;
  assign active   = (state_q != OFF);
  assign accel    = (state_q == ACCEL);
  assign decel    = (state_q == DECEL);
`ifdef CRUISE_FAULT_LATCH_EN
  assign fault    = fault_q;
`else
  assign fault    = 1'b0;
`endif

endmodule

// File: tb/tb_cruise_regulator.sv
// Directed bench for cruise_regulator: engage, ramps, saturation, debounce, cancel, reset, invalid flags.
module tb_cruise_regulator;

  logic       clk = 1'b0;
  logic       reset, engage, cancel;
  logic [7:0] pedal_level;
  logic       G, Eq, L;
  logic [7:0] throttle;
  logic [1:0] state;
  logic       active, accel, decel, fault;

  int compared   = 0;
  int mismatched = 0;

  cruise_regulator #(.W(8), .DEBOUNCE(4)) dut (
    .clk(clk), .reset(reset), .engage(engage), .cancel(cancel),
    .pedal_level(pedal_level), .G(G), .Eq(Eq), .L(L),
    .throttle(throttle), .state(state), .active(active),
    .accel(accel), .decel(decel), .fault(fault)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1ns past the edge for sampling.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic flags(input logic g, input logic e, input logic l);
    G = g; Eq = e; L = l;
  endtask

  task automatic do_reset();
    reset = 1'b1; engage = 1'b0; cancel = 1'b0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic do_engage(input logic [7:0] p);
    pedal_level = p; engage = 1'b1;
    step(1);
    engage = 1'b0;
  endtask

  task automatic test_reset();
    flags(1'b0, 1'b0, 1'b0);
    do_reset();
    compared++;
    if ({state, throttle, active, accel, decel, fault} !== 14'h0) begin
      mismatched++;
      $display("FAIL reset_outputs: got state=%b thr=%h a/ac/de/f=%b%b%b%b want all 0",
               state, throttle, active, accel, decel, fault);
    end
    step(2);
    compared++;
    if (state !== 2'b00 || fault !== 1'b0) begin
      mismatched++;
      $display("FAIL off_invalid_flags: got state=%b fault=%b want 00/0", state, fault);
    end
  endtask

  task automatic test_engage();
    flags(1'b0, 1'b1, 1'b0);
    do_engage(8'h40);
    compared++;
    if (state !== 2'b01 || throttle !== 8'h40 || active !== 1'b1) begin
      mismatched++;
      $display("FAIL engage: got state=%b thr=%h active=%b want 01/40/1", state, throttle, active);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      compared++;
      if (state !== 2'b01 || throttle !== 8'h40) begin
        mismatched++;
        $display("FAIL hold_steady[%0d]: got state=%b thr=%h want 01/40", i, state, throttle);
      end
    end
  endtask

  task automatic test_accel();
    flags(1'b0, 1'b0, 1'b1);
    step(3);
    compared++;
    if (state !== 2'b01 || throttle !== 8'h40) begin
      mismatched++;
      $display("FAIL accel_pre: got state=%b thr=%h want 01/40", state, throttle);
    end
    step(1);
    compared++;
    if (state !== 2'b10 || accel !== 1'b1 || throttle !== 8'h40) begin
      mismatched++;
      $display("FAIL accel_enter: got state=%b accel=%b thr=%h want 10/1/40", state, accel, throttle);
    end
    step(1);
    compared++;
    if (throttle !== 8'h41) begin
      mismatched++;
      $display("FAIL accel_ramp1: got thr=%h want 41", throttle);
    end
    step(1);
    compared++;
    if (throttle !== 8'h42) begin
      mismatched++;
      $display("FAIL accel_ramp2: got thr=%h want 42", throttle);
    end
    flags(1'b0, 1'b1, 1'b0);
    step(3);
    compared++;
    if (state !== 2'b10 || throttle !== 8'h45) begin
      mismatched++;
      $display("FAIL eq_pre: got state=%b thr=%h want 10/45", state, throttle);
    end
    step(1);
    compared++;
    if (state !== 2'b01 || throttle !== 8'h46) begin
      mismatched++;
      $display("FAIL eq_hold: got state=%b thr=%h want 01/46", state, throttle);
    end
    step(3);
    compared++;
    if (state !== 2'b01 || throttle !== 8'h46) begin
      mismatched++;
      $display("FAIL eq_frozen: got state=%b thr=%h want 01/46", state, throttle);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    flags(1'b0, 1'b0, 1'b1);
    do_engage(8'hF0);
    step(4);
    step(14);
    compared++;
    if (state !== 2'b10 || throttle !== 8'hFE) begin
      mismatched++;
      $display("FAIL sat_fe: got state=%b thr=%h want 10/fe", state, throttle);
    end
    step(1);
    compared++;
    if (throttle !== 8'hFF) begin
      mismatched++;
      $display("FAIL sat_ff: got thr=%h want ff", throttle);
    end
    step(3);
    compared++;
    if (throttle !== 8'hFF) begin
      mismatched++;
      $display("FAIL sat_ff_hold: got thr=%h want ff", throttle);
    end
    do_reset();
    flags(1'b1, 1'b0, 1'b0);
    do_engage(8'h05);
    step(4);
    compared++;
    if (state !== 2'b11 || decel !== 1'b1 || throttle !== 8'h05) begin
      mismatched++;
      $display("FAIL decel_enter: got state=%b decel=%b thr=%h want 11/1/05", state, decel, throttle);
    end
    step(4);
    compared++;
    if (throttle !== 8'h01) begin
      mismatched++;
      $display("FAIL decel_01: got thr=%h want 01", throttle);
    end
    step(1);
    compared++;
    if (throttle !== 8'h00) begin
      mismatched++;
      $display("FAIL decel_00: got thr=%h want 00", throttle);
    end
    step(3);
    compared++;
    if (throttle !== 8'h00 || state !== 2'b11) begin
      mismatched++;
      $display("FAIL decel_floor: got state=%b thr=%h want 11/00", state, throttle);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    flags(1'b0, 1'b1, 1'b0);
    do_engage(8'h20);
    flags(1'b1, 1'b0, 1'b0);
    step(3);
    flags(1'b0, 1'b1, 1'b0);
    step(4);
    compared++;
    if (state !== 2'b01 || throttle !== 8'h20) begin
      mismatched++;
      $display("FAIL glitch_g3: got state=%b thr=%h want 01/20", state, throttle);
    end
    flags(1'b0, 1'b0, 1'b1);
    step(2);
    flags(1'b1, 1'b0, 1'b0);
    step(3);
    compared++;
    if (state !== 2'b01) begin
      mismatched++;
      $display("FAIL llg_pre: got state=%b want 01", state);
    end
    step(1);
    compared++;
    if (state !== 2'b11 || throttle !== 8'h20) begin
      mismatched++;
      $display("FAIL llg_decel: got state=%b thr=%h want 11/20", state, throttle);
    end
    step(1);
    compared++;
    if (throttle !== 8'h1F) begin
      mismatched++;
      $display("FAIL llg_ramp: got thr=%h want 1f", throttle);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    flags(1'b0, 1'b0, 1'b1);
    do_engage(8'h10);
    step(6);
    compared++;
    if (state !== 2'b10 || throttle !== 8'h12) begin
      mismatched++;
      $display("FAIL cancel_pre: got state=%b thr=%h want 10/12", state, throttle);
    end
    cancel = 1'b1; engage = 1'b1;
    step(1);
    compared++;
    if (state !== 2'b00 || throttle !== 8'h00 || active !== 1'b0) begin
      mismatched++;
      $display("FAIL cancel_off: got state=%b thr=%h active=%b want 00/00/0", state, throttle, active);
    end
    step(1);
    compared++;
    if (state !== 2'b00) begin
      mismatched++;
      $display("FAIL cancel_beats_engage: got state=%b want 00", state);
    end
    cancel = 1'b0; engage = 1'b0;
  endtask

  task automatic test_reset_mid();
    flags(1'b0, 1'b0, 1'b1);
    do_engage(8'h10);
    step(6);
    reset = 1'b1; engage = 1'b1;
    step(1);
    compared++;
    if ({state, throttle, active, accel, decel, fault} !== 14'h0) begin
      mismatched++;
      $display("FAIL reset_mid: got state=%b thr=%h a/ac/de/f=%b%b%b%b want all 0",
               state, throttle, active, accel, decel, fault);
    end
    reset = 1'b0; engage = 1'b0;
  endtask

  task automatic test_invalid();
    do_reset();
    flags(1'b0, 1'b0, 1'b1);
    do_engage(8'h10);
    step(5);
    flags(1'b1, 1'b0, 1'b1);
    step(1);
`ifdef CRUISE_FAULT_LATCH_EN
    compared++;
    if (fault !== 1'b1 || state !== 2'b00 || throttle !== 8'h00) begin
      mismatched++;
      $display("FAIL fault_set: got fault=%b state=%b thr=%h want 1/00/00", fault, state, throttle);
    end
    flags(1'b0, 1'b1, 1'b0);
    engage = 1'b1;
    step(2);
    compared++;
    if (fault !== 1'b1 || state !== 2'b00) begin
      mismatched++;
      $display("FAIL fault_blocks_engage: got fault=%b state=%b want 1/00", fault, state);
    end
    engage = 1'b0;
    do_reset();
    compared++;
    if (fault !== 1'b0) begin
      mismatched++;
      $display("FAIL fault_clear: got fault=%b want 0", fault);
    end
`else
    compared++;
    if (state !== 2'b10 || fault !== 1'b0 || throttle !== 8'h12) begin
      mismatched++;
      $display("FAIL invalid_nodemand: got state=%b fault=%b thr=%h want 10/0/12", state, fault, throttle);
    end
    step(3);
    compared++;
    if (state !== 2'b10 || throttle !== 8'h15) begin
      mismatched++;
      $display("FAIL invalid_follow: got state=%b thr=%h want 10/15", state, throttle);
    end
`endif
  endtask

  initial begin
    reset = 1'b1; engage = 1'b0; cancel = 1'b0; pedal_level = 8'h00;
    G = 1'b0; Eq = 1'b0; L = 1'b0;
    test_reset();
    test_engage();
    test_accel();
    test_saturate();
    test_glitch();
    test_cancel();
    test_reset_mid();
    test_invalid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
